// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package ifetch_pkg;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    // j/jal target lives in the 256 MB region of the delay-slot PC
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        return {pc4[31:28], inst[25:0], 2'b00};
    endfunction
endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries; flush overrides push and pop.
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ifq_entry_t             wdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output ifq_entry_t             head
);
    localparam int AW = $clog2(DEPTH);

    ifq_entry_t       mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the fetch PC, drives the ICACHE port and buffers words
// for decode; DROP waits out a stalled request that a redirect made stale.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          PREDECODE_J = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   rst_n,
    output logic                   ICACHE_ren,
    output logic                   ICACHE_wen,
    output logic [29:0]            ICACHE_addr,
    output logic [31:0]            ICACHE_wdata,
    input  logic                   ICACHE_stall,
    input  logic [31:0]            ICACHE_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc,
    output logic [$clog2(DEPTH):0] queue_count
);
    typedef enum logic {RUN, DROP} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] saved_pc;
    logic [31:0] redir_pc;
    logic        full;
    logic        empty;
    logic        done;
    logic        is_jump;
    logic        push;
    logic        pop;
    ifq_entry_t  head;

    assign redir_pc     = redirect_pc & 32'hFFFF_FFFC;
    assign ICACHE_ren   = (state == DROP) || !full;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;
    assign ICACHE_addr  = fetch_pc[31:2];
    assign done         = ICACHE_ren && !ICACHE_stall;
    assign is_jump      = PREDECODE_J && (ICACHE_rdata[31:26] == OP_J || ICACHE_rdata[31:26] == OP_JAL);
    assign push         = (state == RUN) && done && !redirect_valid;
    assign pop          = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid   = !empty;
    assign inst         = head.inst;
    assign inst_pc      = head.pc;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk (i_clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ('{pc: fetch_pc, inst: ICACHE_rdata}),
        .full  (full),
        .empty (empty),
        .count (queue_count),
        .head  (head)
    );

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            saved_pc <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        // a stalled request must finish at its old address first
                        if (done || !ICACHE_ren) begin
                            fetch_pc <= redir_pc;
                        end else begin
                            saved_pc <= redir_pc;
                            state    <= DROP;
                        end
                    end else if (done) begin
                        fetch_pc <= is_jump ? jump_target(fetch_pc, ICACHE_rdata) : fetch_pc + 32'd4;
                    end
                end
                DROP: begin
                    if (done) begin
                        fetch_pc <= redirect_valid ? redir_pc : saved_pc;
                        state    <= RUN;
                    end else if (redirect_valid) begin
                        saved_pc <= redir_pc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a reference fetch model and an expected-entry scoreboard.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        rst_n;
    logic        ICACHE_ren, ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_wdata;
    logic        ICACHE_stall;
    logic [31:0] ICACHE_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic [$clog2(DEPTH):0] queue_count;

    int checks = 0;
    int errors = 0;

    ifq_entry_t  sb[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_saved;
    logic        exp_drop;

    always #5 i_clk = ~i_clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PREDECODE_J(1'b1)) dut (
        .i_clk          (i_clk),
        .rst_n          (rst_n),
        .ICACHE_ren     (ICACHE_ren),
        .ICACHE_wen     (ICACHE_wen),
        .ICACHE_addr    (ICACHE_addr),
        .ICACHE_wdata   (ICACHE_wdata),
        .ICACHE_stall   (ICACHE_stall),
        .ICACHE_rdata   (ICACHE_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .queue_count    (queue_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0800_0040 : 32'h2008_0001;
    endfunction

    assign ICACHE_rdata = mem_word({ICACHE_addr, 2'b00});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, advance the model, then step one clock.
    task automatic cyc();
        logic        exp_ren, done, had_valid;
        logic [31:0] w, pc4;
        exp_ren   = exp_drop || (sb.size() != DEPTH);
        had_valid = (sb.size() != 0);
        chk("addr", {34'h0, ICACHE_addr}, {34'h0, exp_pc[31:2]});
        chk("ren", ICACHE_ren, exp_ren);
        chk("count", queue_count, sb.size());
        chk("valid", inst_valid, had_valid);
        chk("wen", ICACHE_wen, 0);
        if (had_valid) begin
            chk("inst", inst, sb[0].inst);
            chk("inst_pc", inst_pc, sb[0].pc);
        end
        done = exp_ren && !ICACHE_stall;
        if (redirect_valid) begin
            sb.delete();
            if (exp_drop) begin
                if (done) begin
                    exp_pc   = redirect_pc & 32'hFFFF_FFFC;
                    exp_drop = 1'b0;
                end else exp_saved = redirect_pc & 32'hFFFF_FFFC;
            end else if (done || !exp_ren) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                exp_saved = redirect_pc & 32'hFFFF_FFFC;
                exp_drop  = 1'b1;
            end
        end else begin
            if (had_valid && inst_ready) void'(sb.pop_front());
            if (exp_drop) begin
                if (done) begin
                    exp_pc   = exp_saved;
                    exp_drop = 1'b0;
                end
            end else if (done) begin
                w = mem_word(exp_pc);
                sb.push_back('{pc: exp_pc, inst: w});
                pc4 = exp_pc + 32'd4;
                if (w[31:26] == 6'h02 || w[31:26] == 6'h03) exp_pc = {pc4[31:28], w[25:0], 2'b00};
                else exp_pc = pc4;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        exp_pc    = 32'h0;
        exp_saved = 32'h0;
        exp_drop  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ICACHE_stall = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #1;
        chk("rst_addr", {34'h0, ICACHE_addr}, 64'h0);
        chk("rst_ren", ICACHE_ren, 1);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_count", queue_count, 0);
        @(posedge i_clk); #1;
        rst_n = 1'b1;

        // streaming with decode always ready
        cyc();
        chk("first_valid", inst_valid, 1);
        chk("first_pc", inst_pc, 32'h0);
        repeat (3) cyc();

        // reset mid-stream
        rst_n = 1'b0; #1;
        model_reset();
        chk("rst2_addr", {34'h0, ICACHE_addr}, 64'h0);
        chk("rst2_count", queue_count, 0);
        @(posedge i_clk); #1;
        rst_n = 1'b1;

        // fill the queue, then drain
        inst_ready = 1'b0;
        repeat (6) cyc();
        chk("fill_count", queue_count, 4);
        chk("fill_ren", ICACHE_ren, 0);
        inst_ready = 1'b1;
        cyc();
        chk("ren_after_pop", ICACHE_ren, 1);
        repeat (3) cyc();

        // j at 0x10 followed in fetch
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        cyc();
        redirect_valid = 1'b0;
        chk("redir_addr", {34'h0, ICACHE_addr}, 64'h4);
        chk("redir_valid", inst_valid, 0);
        cyc();
        chk("jump_addr", {34'h0, ICACHE_addr}, 64'h40);
        chk("jump_pc", inst_pc, 32'h10);
        chk("jump_inst", inst, 32'h0800_0040);
        repeat (3) cyc();

        // redirect during a 5-cycle stall on addr 0x5
        redirect_valid = 1'b1; redirect_pc = 32'h14;
        cyc();
        redirect_valid = 1'b0; ICACHE_stall = 1'b1;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        repeat (3) cyc();
        chk("stall_addr", {34'h0, ICACHE_addr}, 64'h5);
        ICACHE_stall = 1'b0;
        cyc();
        chk("drop_addr", {34'h0, ICACHE_addr}, 64'h80);
        chk("drop_valid", inst_valid, 0);
        cyc();
        chk("drop_pc", inst_pc, 32'h200);
        repeat (2) cyc();

        // two redirects while dropping
        redirect_valid = 1'b1; redirect_pc = 32'h14;
        cyc();
        ICACHE_stall = 1'b1; redirect_pc = 32'h300;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h403;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        ICACHE_stall = 1'b0;
        cyc();
        chk("drop2_addr", {34'h0, ICACHE_addr}, 64'h100);
        repeat (2) cyc();

        // redirect with three entries queued and decode ready
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 3; i++) cyc();
        chk("cnt3", queue_count, 3);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        cyc();
        redirect_valid = 1'b0;
        chk("flush_count", queue_count, 0);
        chk("flush_valid", inst_valid, 0);
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
